// File: rtl/lis_lsu_pkg.sv
// lis_lsu_pkg: op codes, FSM state encodings and access-size helpers for the load/store unit
package lis_lsu_pkg;

   localparam int LIS_OP_WIDTH = 3;

   localparam logic [LIS_OP_WIDTH-1:0] LIS_LB  = 3'd0;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_LH  = 3'd1;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_LW  = 3'd2;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_LBU = 3'd3;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_LHU = 3'd4;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_SB  = 3'd5;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_SH  = 3'd6;
   localparam logic [LIS_OP_WIDTH-1:0] LIS_SW  = 3'd7;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ1  = 3'd1;
   localparam logic [2:0] S_RESP1 = 3'd2;
   localparam logic [2:0] S_REQ2  = 3'd3;
   localparam logic [2:0] S_RESP2 = 3'd4;

   // access size in bytes: 1, 2 or 4
   function automatic logic [2:0] lis_size(input logic [LIS_OP_WIDTH-1:0] op);
      return (op == LIS_LB || op == LIS_LBU || op == LIS_SB) ? 3'd1 :
             (op == LIS_LH || op == LIS_LHU || op == LIS_SH) ? 3'd2 : 3'd4;
   endfunction

   function automatic logic lis_is_store(input logic [LIS_OP_WIDTH-1:0] op);
      return op >= LIS_SB;
   endfunction

endpackage

// File: rtl/lis_lsu_if.sv
// lis_lsu_if: req/gnt/rvalid data-memory port; master = load/store unit, slave = memory
interface lis_lsu_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10
);
   logic                      mem_req_o;
   logic                      mem_gnt_i;
   logic                      mem_we_o;
   logic [DATA_WIDTH/8-1:0]   mem_be_o;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0]     mem_wdata_o;
   logic                      mem_rvalid_i;
   logic [DATA_WIDTH-1:0]     mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/lis_lsu_align.sv
// lis_lsu_align: byte-lane alignment -- be/wdata for both words of an access, read merge and extension
module lis_lsu_align
   import lis_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int OFFS       = $clog2(BE_WIDTH)
) (
   input  logic [LIS_OP_WIDTH-1:0] op,
   input  logic [OFFS-1:0]         off,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH-1:0]   w_lo,
   input  logic [DATA_WIDTH-1:0]   w_hi,
   input  logic                    merge,
   output logic                    misal,
   output logic [BE_WIDTH-1:0]     be_lo,
   output logic [BE_WIDTH-1:0]     be_hi,
   output logic [DATA_WIDTH-1:0]   wd_lo,
   output logic [DATA_WIDTH-1:0]   wd_hi,
   output logic [DATA_WIDTH-1:0]   ext
);
   logic [2:0]              size;
   logic [BE_WIDTH-1:0]     mask;
   logic [2*BE_WIDTH-1:0]   be_full;
   logic [2*DATA_WIDTH-1:0] wd_full;
   logic [DATA_WIDTH-1:0]   m;

   assign size  = lis_size(op);
   assign mask  = size == 3'd1 ? BE_WIDTH'(1) : size == 3'd2 ? BE_WIDTH'(3) : BE_WIDTH'(15);
   assign misal = (int'(off) + int'(size)) > BE_WIDTH;

   // shifting into a double-width vector yields the first word in the low half and the spill-over word in the high half
   assign be_full = {{BE_WIDTH{1'b0}}, mask} << off;
   assign wd_full = {{DATA_WIDTH{1'b0}}, wdata} << (8 * int'(off));
   assign be_lo   = be_full[BE_WIDTH-1:0];
   assign be_hi   = be_full[2*BE_WIDTH-1:BE_WIDTH];
   assign wd_lo   = wd_full[DATA_WIDTH-1:0];
   assign wd_hi   = wd_full[2*DATA_WIDTH-1:DATA_WIDTH];

   // upper lanes of the first word become the low bytes, lower lanes of the second word fill above them
   assign m = merge ? (w_lo >> (8 * int'(off))) | (w_hi << (DATA_WIDTH - 8 * int'(off)))
                    : (w_lo >> (8 * int'(off)));

   assign ext = op == LIS_LB  ? DATA_WIDTH'(signed'(m[7:0])) :
                op == LIS_LBU ? DATA_WIDTH'(m[7:0]) :
                op == LIS_LH  ? DATA_WIDTH'(signed'(m[15:0])) :
                op == LIS_LHU ? DATA_WIDTH'(m[15:0]) :
                DATA_WIDTH'(signed'(m[31:0]));
endmodule

// File: rtl/lis_lsu.sv
// lis_lsu: sequential load/store unit on a req/gnt/rvalid memory port; LIS_MISALIGNED_EN enables split misaligned accesses
module lis_lsu
   import lis_lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    ready_o,
   input  logic [LIS_OP_WIDTH-1:0] LIS_op_i,
   input  logic [DATA_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    done_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    misaligned_o,
   lis_lsu_if.master               mem
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFFS     = $clog2(BE_WIDTH);
   localparam int AW       = MEM_ADDR_WIDTH;

   logic [2:0]              state;
   logic [LIS_OP_WIDTH-1:0] op_q, op_s;
   logic [AW-1:0]           addr_q, addr_s, addr_nxt;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_s, word1_q, w_lo;
   logic                    split_q, misal, reject, accept, rd_merge;
   logic [BE_WIDTH-1:0]     be_lo, be_hi, be_q;
   logic [DATA_WIDTH-1:0]   wd_lo, wd_hi, wd_q, ext;
   logic                    req_q, we_q;
   logic [AW-1:0]           maddr_q;
   logic                    unused_addr;

   assign ready_o  = state == S_IDLE;
   assign accept   = req_i && ready_o;
   assign op_s     = ready_o ? LIS_op_i : op_q;
   assign addr_s   = ready_o ? addr_i[AW-1:0] : addr_q;
   assign wdata_s  = ready_o ? wdata_i : wdata_q;
   assign addr_nxt = addr_q + AW'(BE_WIDTH);
   assign rd_merge = state == S_RESP2;
   assign w_lo     = rd_merge ? word1_q : mem.mem_rdata_i;
   assign unused_addr = ^addr_i[DATA_WIDTH-1:AW];

`ifdef LIS_MISALIGNED_EN
   assign reject = 1'b0;
`else
   assign reject = misal;
`endif

   lis_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .op    (op_s),
      .off   (addr_s[OFFS-1:0]),
      .wdata (wdata_s),
      .w_lo  (w_lo),
      .w_hi  (mem.mem_rdata_i),
      .merge (rd_merge),
      .misal (misal),
      .be_lo (be_lo),
      .be_hi (be_hi),
      .wd_lo (wd_lo),
      .wd_hi (wd_hi),
      .ext   (ext)
   );

   assign mem.mem_req_o   = req_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_be_o    = be_q;
   assign mem.mem_addr_o  = maddr_q;
   assign mem.mem_wdata_o = wd_q;

   // FSM, registered request fields, first-word capture and result/pulse outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         word1_q      <= '0;
         split_q      <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         be_q         <= '0;
         maddr_q      <= '0;
         wd_q         <= '0;
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
         rdata_o      <= '0;
      end else begin
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               op_q    <= LIS_op_i;
               addr_q  <= addr_s;
               wdata_q <= wdata_i;
               split_q <= misal && !reject;
               if (reject) misaligned_o <= 1'b1;
               else begin
                  state   <= S_REQ1;
                  req_q   <= 1'b1;
                  we_q    <= lis_is_store(LIS_op_i);
                  be_q    <= be_lo;
                  maddr_q <= {addr_s[AW-1:OFFS], {OFFS{1'b0}}};
                  wd_q    <= wd_lo;
               end
            end
            S_REQ1: if (mem.mem_gnt_i) begin
               state <= S_RESP1;
               req_q <= 1'b0;
            end
            S_RESP1: if (mem.mem_rvalid_i) begin
               if (split_q) begin
                  state   <= S_REQ2;
                  word1_q <= mem.mem_rdata_i;
                  req_q   <= 1'b1;
                  be_q    <= be_hi;
                  maddr_q <= {addr_nxt[AW-1:OFFS], {OFFS{1'b0}}};
                  wd_q    <= wd_hi;
               end else begin
                  state  <= S_IDLE;
                  done_o <= 1'b1;
                  if (!we_q) rdata_o <= ext;
               end
            end
            S_REQ2: if (mem.mem_gnt_i) begin
               state <= S_RESP2;
               req_q <= 1'b0;
            end
            S_RESP2: if (mem.mem_rvalid_i) begin
               state  <= S_IDLE;
               done_o <= 1'b1;
               if (!we_q) rdata_o <= ext;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lis_lsu.sv
// tb_lis_lsu: directed table-driven bench for lis_lsu plus reset, misaligned and split sequences
module tb_lis_lsu;
   import lis_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        ready, done, mis;
   logic [2:0]  op = '0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   int          nvec = 0, nerr = 0;
   logic [31:0] r_last;

   always #5 clk = ~clk;

   lis_lsu_if #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) mif ();

   lis_lsu #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_i        (req),
      .ready_o      (ready),
      .LIS_op_i     (op),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .done_o       (done),
      .rdata_o      (rdata),
      .misaligned_o (mis),
      .mem          (mif.master)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      int          dly;
      logic [3:0]  be;
      logic [9:0]  maddr;
      logic [31:0] mwdata;
      logic        we;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      @(negedge clk);
      req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      req = 1'b0;
      chk("ready_busy", {31'd0, ready}, 32'd0);
      chk("we", {31'd0, mif.mem_we_o}, {31'd0, v.we});
      chk("addr", {22'd0, mif.mem_addr_o}, {22'd0, v.maddr});
      chk("wdata", mif.mem_wdata_o, v.mwdata);
      for (int i = 0; i <= v.dly; i++) begin
         chk("req_held", {31'd0, mif.mem_req_o}, 32'd1);
         chk("be_held", {28'd0, mif.mem_be_o}, {28'd0, v.be});
         mif.mem_gnt_i = (i == v.dly);
         @(negedge clk);
      end
      mif.mem_gnt_i = 1'b0;
      chk("req_drop", {31'd0, mif.mem_req_o}, 32'd0);
      chk("done_early", {31'd0, done}, 32'd0);
      mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = v.word;
      @(negedge clk);
      mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
      chk("done", {31'd0, done}, 32'd1);
      chk("rdata", rdata, v.rdata);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("ready_idle", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
      tbl[0] = '{LIS_LW,  32'h104, 32'h0,        32'hDEADBEEF, 0, 4'hF, 10'h104, 32'h0,        1'b0, 32'hDEADBEEF};
      tbl[1] = '{LIS_LB,  32'h103, 32'h0,        32'h80FFFFFF, 0, 4'h8, 10'h100, 32'h0,        1'b0, 32'hFFFFFF80};
      tbl[2] = '{LIS_LBU, 32'h103, 32'h0,        32'h80FFFFFF, 1, 4'h8, 10'h100, 32'h0,        1'b0, 32'h00000080};
      tbl[3] = '{LIS_SH,  32'h102, 32'h1234ABCD, 32'h0,        3, 4'hC, 10'h100, 32'hABCD0000, 1'b1, 32'h00000080};
      tbl[4] = '{LIS_LH,  32'h006, 32'h0,        32'h80011234, 1, 4'hC, 10'h004, 32'h0,        1'b0, 32'hFFFF8001};
      tbl[5] = '{LIS_LHU, 32'h3FE, 32'h0,        32'hBEEF0000, 0, 4'hC, 10'h3FC, 32'h0,        1'b0, 32'h0000BEEF};
      tbl[6] = '{LIS_SB,  32'h001, 32'h000000A5, 32'h0,        2, 4'h2, 10'h000, 32'h0000A500, 1'b1, 32'h0000BEEF};
      tbl[7] = '{LIS_SW,  32'h200, 32'hCAFEF00D, 32'h0,        0, 4'hF, 10'h200, 32'hCAFEF00D, 1'b1, 32'h0000BEEF};
      tbl[8] = '{LIS_LB,  32'h005, 32'h0,        32'h00007F00, 0, 4'h2, 10'h004, 32'h0,        1'b0, 32'h0000007F};
      tbl[9] = '{LIS_LH,  32'h000, 32'h0,        32'h1234FFFE, 0, 4'h3, 10'h000, 32'h0,        1'b0, 32'hFFFFFFFE};

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_mis", {31'd0, mis}, 32'd0);
      chk("rst_req", {31'd0, mif.mem_req_o}, 32'd0);
      chk("rst_we", {31'd0, mif.mem_we_o}, 32'd0);
      chk("rst_be", {28'd0, mif.mem_be_o}, 32'd0);
      chk("rst_addr", {22'd0, mif.mem_addr_o}, 32'd0);
      chk("rst_wdata", mif.mem_wdata_o, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 10; k++) run(tbl[k]);
      r_last = tbl[9].rdata;

`ifdef LIS_MISALIGNED_EN
      @(negedge clk);
      req = 1'b1; op = LIS_LW; addr = 32'h3FF; wdata = '0;
      @(negedge clk);
      req = 1'b0;
      chk("sp_req1", {31'd0, mif.mem_req_o}, 32'd1);
      chk("sp_be1", {28'd0, mif.mem_be_o}, 32'h8);
      chk("sp_addr1", {22'd0, mif.mem_addr_o}, 32'h3FC);
      mif.mem_gnt_i = 1'b1;
      @(negedge clk);
      mif.mem_gnt_i = 1'b0;
      mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h11223344;
      @(negedge clk);
      mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
      chk("sp_done_mid", {31'd0, done}, 32'd0);
      chk("sp_req2", {31'd0, mif.mem_req_o}, 32'd1);
      chk("sp_be2", {28'd0, mif.mem_be_o}, 32'h7);
      chk("sp_addr2", {22'd0, mif.mem_addr_o}, 32'h000);
      mif.mem_gnt_i = 1'b1;
      @(negedge clk);
      mif.mem_gnt_i = 1'b0;
      mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h55667788;
      @(negedge clk);
      mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
      chk("sp_done", {31'd0, done}, 32'd1);
      chk("sp_rdata", rdata, 32'h66778811);
      chk("sp_mis", {31'd0, mis}, 32'd0);
      r_last = 32'h66778811;
`else
      @(negedge clk);
      req = 1'b1; op = LIS_LH; addr = 32'h003; wdata = '0;
      @(negedge clk);
      req = 1'b0;
      chk("mis_pulse", {31'd0, mis}, 32'd1);
      chk("mis_noreq", {31'd0, mif.mem_req_o}, 32'd0);
      chk("mis_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      chk("mis_pulse_end", {31'd0, mis}, 32'd0);
      chk("mis_nodone", {31'd0, done}, 32'd0);
      chk("mis_rdata", rdata, r_last);
      req = 1'b1; op = LIS_SW; addr = 32'h102; wdata = 32'h01020304;
      @(negedge clk);
      req = 1'b0;
      chk("mis2_pulse", {31'd0, mis}, 32'd1);
      chk("mis2_noreq", {31'd0, mif.mem_req_o}, 32'd0);
      @(negedge clk);
      chk("mis2_end", {31'd0, mis}, 32'd0);
      chk("mis2_noreq2", {31'd0, mif.mem_req_o}, 32'd0);
`endif

      @(negedge clk);
      req = 1'b1; op = LIS_LW; addr = 32'h010; wdata = '0;
      @(negedge clk);
      req = 1'b0;
      mif.mem_gnt_i = 1'b1;
      @(negedge clk);
      mif.mem_gnt_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rr_req", {31'd0, mif.mem_req_o}, 32'd0);
      chk("rr_done", {31'd0, done}, 32'd0);
      chk("rr_ready", {31'd0, ready}, 32'd1);
      mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'hFFFF0000;
      @(negedge clk);
      mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
      chk("rr_late_done", {31'd0, done}, 32'd0);
      chk("rr_late_rdata", rdata, 32'd0);
      chk("rr_late_ready", {31'd0, ready}, 32'd1);
      run('{LIS_LW, 32'h010, 32'h0, 32'h0BADF00D, 0, 4'hF, 10'h010, 32'h0, 1'b0, 32'h0BADF00D});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
